// File: rtl/encoder_ham.sv
// Hamming (21,16) encoder with a 2-entry registered output FIFO.
// Codeword layout matches decoder_ham: cw index = Hamming position - 1,
// parity at indices 0,1,3,7,15 (even parity), data in the remaining bits.
// Optional error injection is enabled by defining HAM_ERR_INJ_EN, which adds
// err_en_i / err_pos_i to flip one codeword bit on an input transfer.
module encoder_ham #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      dat_i,
  input  logic             vld_i,
  output logic             rdy_o,
  output logic [20:0]      dat_o,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic [CNT_W-1:0] cnt_o
`ifdef HAM_ERR_INJ_EN
  ,
  input  logic             err_en_i,
  input  logic [4:0]       err_pos_i
`endif
);

  logic [20:0]      cw;
  logic [20:0]      mem_q [2];
  logic [20:0]      mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // Place data bits, derive the five even-parity bits, then apply injection.
  always_comb begin
    // NOTE: every variable gets a default at the top of a combinational
    // block so no path leaves it unassigned, which would infer a latch.
    cw        = '0;
    cw[2]     = dat_i[0];
    cw[6:4]   = dat_i[3:1];
    cw[14:8]  = dat_i[10:4];
    cw[20:16] = dat_i[15:11];
    cw[0]  = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10] ^ cw[12] ^ cw[14]
           ^ cw[16] ^ cw[18] ^ cw[20];
    cw[1]  = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10] ^ cw[13] ^ cw[14]
           ^ cw[17] ^ cw[18];
    cw[3]  = cw[4] ^ cw[5] ^ cw[6] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14]
           ^ cw[19] ^ cw[20];
    cw[7]  = ^cw[14:8];
    cw[15] = ^cw[20:16];
`ifdef HAM_ERR_INJ_EN
    if (err_en_i && (err_pos_i >= 5'd1) && (err_pos_i <= 5'd21)) begin
      cw = cw ^ (21'(1) << (err_pos_i - 5'd1));
    end
`endif
  end

  assign push = vld_i && rdy_q;
  assign pop  = (occ_q != 2'd0) && rdy_i;

  // FIFO next-state: pointers, occupancy, storage, ready and word counter.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = cw;
      wr_ptr_d        = ~wr_ptr_q;
      cnt_d           = cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    rdy_d = (occ_d < 2'd2);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the two buffer entries are reset too so dat_o reads 0 out of
      // reset; a deep RAM would normally be left unreset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      rdy_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdy_o = rdy_q;
  assign vld_o = (occ_q != 2'd0);
  assign dat_o = mem_q[rd_ptr_q];
  assign cnt_o = cnt_q;

endmodule

// File: doc/encoder_ham.md
Name: encoder_ham

Overview:
- Hamming (21,16) encoder: takes a 16-bit data word and produces a 21-bit codeword with 5 parity bits. The codeword format is exactly the one decoder_ham consumes.
- Sits directly upstream of decoder_ham, with the channel between them.
- Valid/ready on both sides.
- 2-entry output buffer so upstream is not stalled combinationally by downstream ready.
- Free-running count of encoded words.

Parameters:
- CNT_W, 16, width of the encoded-word counter cnt_o.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- dat_i  input  16  data word to encode.
- vld_i  input  1  dat_i valid.
- rdy_o  output  1  encoder can accept; registered.
- dat_o  output  21  codeword at the buffer head.
- vld_o  output  1  dat_o valid.
- rdy_i  input  1  downstream accepts dat_o.
- cnt_o  output  CNT_W  number of words accepted since reset, modulo 2^CNT_W.

Behaviour:
- Reset and clocking: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Transfers:
  - Input transfer: vld_i && rdy_o at a rising edge.
  - Output transfer: vld_o && rdy_i at a rising edge.
- Codeword mapping (cw index = Hamming position - 1):
  - cw[2] = d[0]
  - cw[6:4] = d[3:1]
  - cw[14:8] = d[10:4]
  - cw[20:16] = d[15:11]
- Parity bits (even parity):
  - cw[0] = XOR of cw[2,4,6,8,10,12,14,16,18,20]
  - cw[1] = XOR of cw[2,5,6,9,10,13,14,17,18]
  - cw[3] = XOR of cw[4,5,6,11,12,13,14,19,20]
  - cw[7] = XOR of cw[8..14]
  - cw[15] = XOR of cw[16..20]
  - Consequence: decoder_ham computes syndrome 0 for every unmodified codeword.
- Encoding is combinational on dat_i; the codeword is written into the buffer on input transfer.
- Buffer:
  - 2-entry FIFO: write pointer, read pointer (1 bit each), occupancy count 0..2.
  - dat_o = entry at the read pointer; vld_o = (occupancy != 0).
  - Both are driven from registers; no combinational path from dat_i or vld_i.
- Latency: word accepted at edge N with the buffer empty has vld_o=1 and dat_o=codeword after edge N.
- Occupancy update per edge:
  - +1 on input transfer only.
  - -1 on output transfer only.
  - Unchanged when both occur.
- rdy_o registered:
  - Next value is 1 iff next occupancy < 2.
  - Full buffer: rdy_o=0, no write, vld_i ignored.
  - Occupancy 1 with push and pop in the same cycle: occupancy stays 1, rdy_o stays 1.
- Ordering is FIFO. Pointers wrap 1 -> 0.
- dat_o, vld_o and buffer contents hold stable while vld_o=1 and rdy_i=0.
- cnt_o increments by 1 on each input transfer; wraps from 2^CNT_W-1 to 0.
- Reset values (async, immediate): rdy_o=0, vld_o=0, dat_o=0, cnt_o=0, occupancy=0, pointers=0.
  - Buffer entries cleared to 0.
  - rdy_o rises at the first rising edge with rst_i low.
- Reset mid-operation: all in-flight words are discarded; no partial output.

Optional Feature:
- Macro: HAM_ERR_INJ_EN.
- Defined:
  - Adds ports err_en_i (input, 1) and err_pos_i (input, 5).
  - On an input transfer with err_en_i=1 and err_pos_i in 1..21, the stored codeword has bit err_pos_i-1 inverted.
  - err_pos_i of 0 or 22..31 injects nothing.
  - cnt_o is unaffected by injection.
- Not defined: both ports absent; codewords are always clean.
- Purpose: exercise decoder_ham single-bit correction end to end.

Test Plan:
1. Reset, then push d=16'h0000, 16'h0001, 16'hFFFF, 16'h8000 with rdy_i=1 -> dat_o 21'h000000, 21'h000007, 21'h1FFFFE, 21'h108009, each one cycle after acceptance; cnt_o=4.
2. rdy_i=0, vld_i=1 for 3 cycles with data 16'h1111, 16'h2222, 16'h3333 -> first two accepted, rdy_o=0 after the second, cnt_o=2. Then rdy_i=1 -> outputs arrive in order, 16'h3333 is accepted once rdy_o returns, dat_o stable while stalled.
3. Continuous vld_i=1, rdy_i=1 for 100 random words -> one word per cycle after the first, rdy_o never drops. Chained into decoder_ham, dat_o of decoder equals the input sequence.
4. Assert rst_i asynchronously with occupancy 2 -> vld_o=0, rdy_o=0, cnt_o=0 without a clock edge. After release, no stale words emerge.
5. CNT_W=4, push 17 words -> cnt_o reads 1.
6. HAM_ERR_INJ_EN: d=16'h0001, err_en_i=1, err_pos_i=3 -> dat_o 21'h000003, decoder_ham outputs 16'h0001. err_pos_i=0 or 22 -> dat_o 21'h000007.
